// File: rtl/y86_stage_sequencer.sv
// Multi-cycle stage sequencer for the sequential Y86-64 core.
// Walks each instruction through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK
// and PC-UPDATE. It drives one stage enable per cycle, owns the architectural
// PC and retired-instruction counter, runs the data-memory handshake, and
// tracks the Y86 status code.
module y86_stage_sequencer #(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter int          MEM_WAIT_MAX = 15,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             dmem_ack,
    input  logic             dmem_error,
    input  logic [63:0]      next_pc,
    output logic [63:0]      pc,
    output logic [2:0]       stage,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             memory_en,
    output logic             writeback_en,
    output logic             pc_en,
    output logic             dmem_req,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_MEMORY    = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;
    localparam logic [2:0] S_PCUPD     = 3'd6;
    localparam logic [2:0] S_HALT      = 3'd7;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // The wait counter indexes MEMORY cycles 0 .. MEM_WAIT_MAX-1.
    // Reaching the last index without an ack is the timeout.
    localparam int                WAIT_W    = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    logic [2:0]        state_q, state_d;
    logic [63:0]       pc_q, pc_d;
    logic [2:0]        stat_q, stat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              isMem_q, isMem_d;
    logic              memIcode;

    // Classify the icode as one of the instructions that access data memory.
    always_comb begin
        memIcode = 1'b0;
        case (icode)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: memIcode = 1'b1;
            default:                            memIcode = 1'b0;
        endcase
    end

    // Compute the next state. Faulting and halt instructions go straight to
    // HALT without touching pc or the retired count.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stat_d  = stat_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        isMem_d = isMem_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                isMem_d = memIcode;
                if (imem_error) begin
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end else if (!instr_valid) begin
                    state_d = S_HALT;
                    stat_d  = STAT_INS;
                end else if (icode == 4'h0) begin
                    state_d = S_HALT;
                    stat_d  = STAT_HLT;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_MEMORY;
                wait_d  = '0;
            end
            S_MEMORY: begin
                if (!isMem_q) begin
                    state_d = S_WRITEBACK;
                end else if (dmem_ack) begin
                    if (dmem_error) begin
                        state_d = S_HALT;
                        stat_d  = STAT_ADR;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WRITEBACK: begin
                state_d = S_PCUPD;
            end
            S_PCUPD: begin
                pc_d    = next_pc;
                cnt_d   = cnt_q + 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register all sequencer state. Reset overrides everything, including an
    // in-flight memory handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            stat_q  <= STAT_AOK;
            cnt_q   <= '0;
            wait_q  <= '0;
            isMem_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stat_q  <= stat_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            isMem_q <= isMem_d;
        end
    end

    assign pc           = pc_q;
    assign stage        = state_q;
    assign stat         = stat_q;
    assign instr_count  = cnt_q;
    assign fetch_en     = (state_q == S_FETCH);
    assign decode_en    = (state_q == S_DECODE);
    assign execute_en   = (state_q == S_EXECUTE);
    assign memory_en    = (state_q == S_MEMORY);
    assign writeback_en = (state_q == S_WRITEBACK);
    assign pc_en        = (state_q == S_PCUPD);
    assign halted       = (state_q == S_HALT);
    assign dmem_req     = (state_q == S_MEMORY) && isMem_q;

endmodule

// File: tb/tb_y86_stage_sequencer.sv
// Self-checking bench for y86_stage_sequencer.
// Directed sequences and a FETCH-case table are followed by randomized
// instruction streams. The expected per-cycle behaviour of each random stream
// is expanded from an instruction-level plan.
module tb_y86_stage_sequencer;

    localparam logic [63:0] RESET_PC = 64'h100;
    localparam int          MAX      = 15;

    logic        clk = 1'b0;
    logic        reset, start, instr_valid, imem_error, dmem_ack, dmem_error;
    logic [3:0]  icode;
    logic [63:0] next_pc;
    logic [63:0] pc;
    logic [2:0]  stage, stat;
    logic        fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en;
    logic        dmem_req, halted;
    logic [3:0]  instr_count;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic       iv;
        logic       ie;
        logic [3:0] ic;
        logic [2:0] expStage;
        logic [2:0] expStat;
        string      name;
    } fetchVec_t;

    fetchVec_t vecs[6];

    y86_stage_sequencer #(
        .RESET_PC    (RESET_PC),
        .MEM_WAIT_MAX(MAX),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .icode       (icode),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .dmem_ack    (dmem_ack),
        .dmem_error  (dmem_error),
        .next_pc     (next_pc),
        .pc          (pc),
        .stage       (stage),
        .fetch_en    (fetch_en),
        .decode_en   (decode_en),
        .execute_en  (execute_en),
        .memory_en   (memory_en),
        .writeback_en(writeback_en),
        .pc_en       (pc_en),
        .dmem_req    (dmem_req),
        .stat        (stat),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    function automatic logic coin();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Drive one cycle's inputs, then advance to the next falling edge.
    task automatic applyStimulus(input logic rst, input logic st, input logic [3:0] ic,
                                 input logic iv, input logic ie, input logic ack,
                                 input logic err, input logic [63:0] npc);
        reset       = rst;
        start       = st;
        icode       = ic;
        instr_valid = iv;
        imem_error  = ie;
        dmem_ack    = ack;
        dmem_error  = err;
        next_pc     = npc;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Compare every output against the expected stage/pc/stat/count/request.
    task automatic checkOutput(input string name, input logic [2:0] expStage,
                               input logic [63:0] expPc, input logic [2:0] expStat,
                               input logic [3:0] expCnt, input logic expReq);
        logic [5:0] expEn, actEn;
        logic       expHalt;
        expEn = 6'b0;
        if (expStage >= 3'd1 && expStage <= 3'd6) expEn = 6'b100000 >> (expStage - 3'd1);
        expHalt = (expStage == 3'd7);
        actEn   = {fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en};
        checks++;
        if ({stage, actEn, dmem_req, stat, halted, pc, instr_count} ===
            {expStage, expEn, expReq, expStat, expHalt, expPc, expCnt}) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got stage=%0d en=%b req=%b stat=%0d halted=%b pc=%h cnt=%0d, want stage=%0d en=%b req=%b stat=%0d halted=%b pc=%h cnt=%0d",
                     name, stage, actEn, dmem_req, stat, halted, pc, instr_count,
                     expStage, expEn, expReq, expStat, expHalt, expPc, expCnt);
        end
    endtask

    // Reset, confirm IDLE, then start so the next cycle is FETCH at RESET_PC.
    task automatic resetAndStart();
        applyStimulus(1, 0, 4'h1, 1, 0, 0, 0, 64'h0);
        checkOutput("reset idle", 3'd0, RESET_PC, 3'd1, 4'd0, 0);
        applyStimulus(0, 1, 4'h1, 1, 0, 0, 0, 64'h0);
    endtask

    // Step a legal non-memory instruction through all six stages.
    task automatic runStages(input logic [3:0] ic, input logic [63:0] npc,
                             input logic [63:0] curPc, input logic [3:0] curCnt);
        for (int s = 1; s <= 6; s++) begin
            checkOutput("nonmem stage", 3'(s), curPc, 3'd1, curCnt, 0);
            applyStimulus(0, 0, ic, 1, 0, 0, 0, npc);
        end
    endtask

    // One random program: reset, then up to 40 instructions. Outcomes are
    // drawn per instruction and expanded into the expected cycle sequence.
    task automatic runRandomProgram();
        logic [63:0] mPc, npc;
        logic [3:0]  mCnt, ic;
        logic        iv, ie, e;
        logic [2:0]  expStat;
        int          r, d;
        mPc  = RESET_PC;
        mCnt = 4'd0;
        resetAndStart();
        for (int n = 0; n < 40; n++) begin
            r  = $urandom_range(0, 99);
            iv = !(r >= 4 && r < 8);
            ie = (r >= 8 && r < 11);
            ic = (r < 4) ? 4'h0 : 4'($urandom_range(1, 15));
            checkOutput("rnd fetch", 3'd1, mPc, 3'd1, mCnt, 0);
            applyStimulus(0, coin(), ic, iv, ie, coin(), coin(), rnd64());
            if (ie || !iv || ic == 4'h0) begin
                expStat = ie ? 3'd3 : (!iv ? 3'd4 : 3'd2);
                checkOutput("rnd fetch fault", 3'd7, mPc, expStat, mCnt, 0);
                applyStimulus(0, 1, ic, 1, 0, 1, 0, rnd64());
                checkOutput("rnd halt sticky", 3'd7, mPc, expStat, mCnt, 0);
                return;
            end
            checkOutput("rnd decode", 3'd2, mPc, 3'd1, mCnt, 0);
            applyStimulus(0, coin(), ic, 1, 0, coin(), coin(), rnd64());
            checkOutput("rnd execute", 3'd3, mPc, 3'd1, mCnt, 0);
            applyStimulus(0, coin(), ic, 1, 0, coin(), coin(), rnd64());
            if (ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
                d = $urandom_range(0, MAX);
                e = ($urandom_range(0, 7) == 0);
                for (int j = 0; j < MAX; j++) begin
                    checkOutput("rnd memory wait", 3'd4, mPc, 3'd1, mCnt, 1);
                    applyStimulus(0, coin(), ic, 1, 0, (j == d), (j == d) ? e : coin(), rnd64());
                    if (j == d) break;
                end
                if (d == MAX || e) begin
                    checkOutput("rnd memory fault", 3'd7, mPc, 3'd3, mCnt, 0);
                    return;
                end
            end else begin
                checkOutput("rnd memory skip", 3'd4, mPc, 3'd1, mCnt, 0);
                applyStimulus(0, coin(), ic, 1, 0, 0, coin(), rnd64());
            end
            checkOutput("rnd writeback", 3'd5, mPc, 3'd1, mCnt, 0);
            applyStimulus(0, coin(), ic, 1, 0, coin(), coin(), rnd64());
            checkOutput("rnd pcupd", 3'd6, mPc, 3'd1, mCnt, 0);
            npc = rnd64();
            applyStimulus(0, coin(), ic, 1, 0, coin(), coin(), npc);
            mPc  = npc;
            mCnt = mCnt + 4'd1;
        end
    endtask

    // Main test sequence.
    initial begin
        vecs[0] = '{1'b1, 1'b0, 4'h0, 3'd7, 3'd2, "fetch halt icode"};
        vecs[1] = '{1'b0, 1'b0, 4'h1, 3'd7, 3'd4, "fetch invalid"};
        vecs[2] = '{1'b0, 1'b1, 4'h1, 3'd7, 3'd3, "fetch imem over invalid"};
        vecs[3] = '{1'b1, 1'b1, 4'h0, 3'd7, 3'd3, "fetch imem over halt"};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 3'd7, 3'd4, "fetch invalid over halt"};
        vecs[5] = '{1'b1, 1'b0, 4'h6, 3'd2, 3'd1, "fetch legal"};

        applyStimulus(1, 0, 4'h1, 1, 0, 0, 0, 64'h0);
        checkOutput("reset state", 3'd0, RESET_PC, 3'd1, 4'd0, 0);
        applyStimulus(0, 0, 4'h1, 1, 0, 1, 0, 64'h0);
        checkOutput("idle without start", 3'd0, RESET_PC, 3'd1, 4'd0, 0);

        // Two nops with next_pc = pc + 1.
        applyStimulus(0, 1, 4'h1, 1, 0, 0, 0, 64'h0);
        runStages(4'h1, RESET_PC + 64'd1, RESET_PC, 4'd0);
        runStages(4'h1, RESET_PC + 64'd2, RESET_PC + 64'd1, 4'd1);
        checkOutput("after two nops", 3'd1, RESET_PC + 64'd2, 3'd1, 4'd2, 0);

        // mrmovq with the ack three cycles after MEMORY entry.
        applyStimulus(0, 0, 4'h5, 1, 0, 0, 0, 64'h0);
        checkOutput("mrmovq decode", 3'd2, RESET_PC + 64'd2, 3'd1, 4'd2, 0);
        applyStimulus(0, 0, 4'h5, 1, 0, 1, 0, 64'h0);
        checkOutput("mrmovq execute", 3'd3, RESET_PC + 64'd2, 3'd1, 4'd2, 0);
        applyStimulus(0, 0, 4'h5, 1, 0, 1, 0, 64'h0);
        for (int j = 0; j < 4; j++) begin
            checkOutput("mrmovq memory req", 3'd4, RESET_PC + 64'd2, 3'd1, 4'd2, 1);
            applyStimulus(0, 0, 4'h5, 1, 0, (j == 3), 0, 64'h0);
        end
        checkOutput("mrmovq writeback", 3'd5, RESET_PC + 64'd2, 3'd1, 4'd2, 0);
        applyStimulus(0, 0, 4'h5, 1, 0, 0, 0, 64'h0);
        checkOutput("mrmovq pcupd", 3'd6, RESET_PC + 64'd2, 3'd1, 4'd2, 0);
        applyStimulus(0, 0, 4'h5, 1, 0, 0, 0, 64'h40);
        checkOutput("mrmovq retired", 3'd1, 64'h40, 3'd1, 4'd3, 0);

        // Reset in the middle of a memory handshake.
        applyStimulus(0, 0, 4'h8, 1, 0, 0, 0, 64'h0);
        applyStimulus(0, 0, 4'h8, 1, 0, 0, 0, 64'h0);
        applyStimulus(0, 0, 4'h8, 1, 0, 0, 0, 64'h0);
        checkOutput("call memory req", 3'd4, 64'h40, 3'd1, 4'd3, 1);
        applyStimulus(1, 0, 4'h8, 1, 0, 0, 0, 64'h0);
        checkOutput("reset mid handshake", 3'd0, RESET_PC, 3'd1, 4'd0, 0);

        // rmmovq with no ack: times out after MAX MEMORY cycles.
        applyStimulus(0, 1, 4'h1, 1, 0, 0, 0, 64'h0);
        runStages(4'h1, 64'h77, RESET_PC, 4'd0);
        applyStimulus(0, 0, 4'h4, 1, 0, 0, 0, 64'h0);
        applyStimulus(0, 0, 4'h4, 1, 0, 0, 0, 64'h0);
        applyStimulus(0, 0, 4'h4, 1, 0, 0, 0, 64'h0);
        for (int j = 0; j < MAX; j++) begin
            checkOutput("rmmovq waiting", 3'd4, 64'h77, 3'd1, 4'd1, 1);
            applyStimulus(0, 0, 4'h4, 1, 0, 0, 0, 64'h0);
        end
        checkOutput("rmmovq timeout", 3'd7, 64'h77, 3'd3, 4'd1, 0);

        // HALT ignores start and ack; reset plus start resumes from RESET_PC.
        for (int j = 0; j < 3; j++) begin
            applyStimulus(0, 1, 4'h5, 1, 0, 1, 0, 64'h55);
            checkOutput("halt sticky", 3'd7, 64'h77, 3'd3, 4'd1, 0);
        end
        resetAndStart();
        checkOutput("resume fetch", 3'd1, RESET_PC, 3'd1, 4'd0, 0);

        // FETCH priority table.
        foreach (vecs[i]) begin
            resetAndStart();
            applyStimulus(0, 0, vecs[i].ic, vecs[i].iv, vecs[i].ie, 0, 0, 64'h0);
            checkOutput(vecs[i].name, vecs[i].expStage, RESET_PC, vecs[i].expStat, 4'd0, 0);
        end

        for (int p = 0; p < 40; p++) runRandomProgram();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
